alu_mdu_seq: RTL and testbench
==============================

// Module: alu_mdu_seq
// PURPOSE
//  Parametrised sequential ALU with a MIPS-style multiply/divide unit (HI/LO registers).
//  Replaces the switch-driven combinational ALU path; sits between decode and writeback.
//  Operands are accepted on a valid/ready handshake. Results leave on a valid/ready
//  handshake. Logic ops take 1 cycle; MULT/DIV run iteratively over WIDTH cycles.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=8, power of two)
//  OP_W    4   opcode width (fixed encoding below)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       A/B/AluOp valid this cycle
//  in_ready   out  1       unit can accept an operation this cycle
//  A          in   WIDTH   operand A
//  B          in   WIDTH   operand B
//  AluOp      in   OP_W    operation select
//  out_valid  out  1       res/flags valid
//  out_ready  in   1       consumer takes result this cycle
//  res        out  WIDTH   result
//  zero       out  1       res == 0
//  ovf        out  1       signed overflow (ADD/SUB only, else 0)
//  div0       out  1       divide by zero occurred (DIV/DIVU only, else 0)
// BEHAVIOUR
//  Opcodes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLL, 6 SUB, 7 SLT(signed),
//   8 SRL, 9 SRA, A MULTU, B MULT, C DIVU, D DIV, E MFHI, F MFLO.
//  Shifts: A shifted by B[$clog2(WIDTH)-1:0]. SLT: res = {0..,$signed(A)<$signed(B)}.
//  ADD/SUB wrap modulo 2^WIDTH. ovf = operand signs agree (SUB: A vs ~B), result sign differs.
//  Reset: FSM=IDLE, HI=LO=0, counter=0, out_valid=0, res=0, zero/ovf/div0=0.
//  Reset mid-operation aborts it; partial products are discarded; HI/LO return to 0.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  Output register holds res/flags stable while out_valid && !out_ready.
//  out_valid drops after a cycle with out_ready=1, unless a new result loads in that cycle.
//  FSM: IDLE -> (accept op 0-9,E,F) IDLE: result registered, out_valid next cycle (latency 1).
//   IDLE -> (accept A/B) MUL: shift-add, one bit per cycle, WIDTH cycles.
//   IDLE -> (accept C/D, B!=0) DIV: restoring, one quotient bit per cycle, WIDTH cycles.
//   MUL/DIV -> DONE on last iteration. DONE: sign fixup, HI/LO written, res=LO,
//   out_valid=1; -> IDLE. Mul/div latency = WIDTH+2 cycles from accept to out_valid.
//  MULT/MULTU: {HI,LO} = full 2*WIDTH product. MULT is signed: magnitudes, negate if signs differ.
//  DIV/DIVU: LO = quotient, HI = remainder.
//   DIV: quotient truncates toward zero; remainder takes the sign of A.
//   DIV MIN/-1: LO=MIN, HI=0, ovf=0.
//  Divide by zero: no iteration. Next cycle HI=A, LO=all ones, res=LO, div0=1 (latency 1).
//  MFHI/MFLO return HI/LO and never change them. A single-cycle op leaves HI/LO unchanged.
//  zero is computed from the registered res for every opcode.
//  in_valid while in_ready=0 is ignored. The source holds operands until accept.
// TESTING
//  ADD A=7FFFFFFF B=1 -> 1 cycle later res=80000000, ovf=1, zero=0.
//  SUB A=5 B=5, out_ready=0 for 3 cycles -> res=0, zero=1 held; in_ready=0 until taken.
//  MULT A=FFFFFFFD(-3) B=7 -> after 34 cycles LO=FFFFFFEB, HI=FFFFFFFF; MFHI -> FFFFFFFF.
//  DIV A=FFFFFFF9(-7) B=2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU A=9 B=0 -> next cycle res=FFFFFFFF, div0=1, MFHI=9.
//  Assert rst at cycle 10 of MULTU -> out_valid=0 and in_ready=1 immediately; MFLO -> 0.
//  Back-to-back: XOR then SRA (A=80000000, B=4) with out_ready=1 -> res 1 cycle apart, SRA=F8000000.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// Sequential ALU with an iterative MIPS-style multiply/divide unit (HI/LO).
// Single-cycle ops register their result directly; MULT/DIV iterate one bit per cycle.
module alu_mdu_seq #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  AluOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ovf,
    output logic             div0,
    output logic [1:0]       dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_valid is ignored while in_ready is low, and res/flags stay frozen while out_valid && !out_ready.
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_NOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(10);
    localparam logic [OP_W-1:0] OP_MULT = OP_W'(11);
    localparam logic [OP_W-1:0] OP_DIVU = OP_W'(12);
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_MFHI = OP_W'(14);
    localparam logic [OP_W-1:0] OP_MFLO = OP_W'(15);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     hi, lo, opb;
    logic [2*WIDTH-1:0]   p;
    logic [SH_W-1:0]      cnt;
    logic                 neg_lo, neg_hi, is_div;

    logic                 accept, is_mul_op, is_div_op, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag, add_sum, sub_diff, alu_res;
    logic                 alu_ovf;
    logic [SH_W-1:0]      shamt;
    logic [WIDTH:0]       mul_sum, div_shift, div_sub;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix, fin_hi, fin_lo;

    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    assign is_mul_op = (AluOp == OP_MULTU) || (AluOp == OP_MULT);
    assign is_div_op = (AluOp == OP_DIVU) || (AluOp == OP_DIV);
    assign signed_op = (AluOp == OP_MULT) || (AluOp == OP_DIV);
    assign a_neg     = signed_op && A[WIDTH-1];
    assign b_neg     = signed_op && B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    assign add_sum  = A + B;
    assign sub_diff = A - B;
    assign shamt    = B[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (AluOp)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_ADD: begin
                alu_res = add_sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_XOR: alu_res = A ^ B;
            OP_NOR: alu_res = ~(A | B);
            OP_SLL: alu_res = A << shamt;
            OP_SUB: begin
                alu_res = sub_diff;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = $signed(A) >>> shamt;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Shift-add multiplier: p = {partial, multiplier}; restoring divider: p = {remainder, quotient}.
    assign mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mul_next  = {mul_sum, p[WIDTH-1:1]};
    assign div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign div_sub   = div_shift - {1'b0, opb};
    assign div_ge    = div_shift >= {1'b0, opb};
    assign div_next  = {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]), p[WIDTH-2:0], div_ge};

    assign prod_fix = neg_lo ? -p : p;
    assign quo_fix  = neg_lo ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    assign rem_fix  = neg_hi ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    assign fin_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fin_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hi        <= '0;
            lo        <= '0;
            opb       <= '0;
            p         <= '0;
            cnt       <= '0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            is_div    <= 1'b0;
            out_valid <= 1'b0;
            res       <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            div0      <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (is_mul_op || (is_div_op && (B != '0))) begin
                            p      <= {{WIDTH{1'b0}}, a_mag};
                            opb    <= b_mag;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
                            is_div <= is_div_op;
                            state  <= is_div_op ? S_DIV : S_MUL;
                        end else if (is_div_op) begin
                            hi        <= A;
                            lo        <= '1;
                            res       <= '1;
                            zero      <= 1'b0;
                            ovf       <= 1'b0;
                            div0      <= 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            res       <= alu_res;
                            zero      <= (alu_res == '0);
                            ovf       <= alu_ovf;
                            div0      <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    p   <= (state == S_DIV) ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == SH_W'(WIDTH-1)) state <= S_DONE;
                end
                S_DONE: begin
                    hi        <= fin_hi;
                    lo        <= fin_lo;
                    res       <= fin_lo;
                    zero      <= (fin_lo == '0);
                    ovf       <= 1'b0;
                    div0      <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq: a reference model pushes {res,zero,ovf,div0}
// per operation and a negedge monitor pops/compares on every output transfer.
module tb_alu_mdu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, res;
    logic [3:0]   AluOp;
    logic         zero, ovf, div0;
    logic [1:0]   dbg_state;

    alu_mdu_seq #(.WIDTH(W), .OP_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .AluOp(AluOp), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .zero(zero), .ovf(ovf), .div0(div0), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [W+2:0] exp_q[$];
    logic [W+2:0] mon_exp;
    logic [W-1:0] mhi, mlo;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_pop = 0;
    int prev_pop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: returns {res, zero, ovf, div0} and tracks HI/LO.
    function automatic logic [W+2:0] model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic ov, d0;
        logic [63:0] up;
        logic signed [63:0] sa, sb, sp, sq, sr;
        r = '0; ov = 1'b0; d0 = 1'b0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'h3: r = a ^ b;
            4'h4: r = ~(a | b);
            4'h5: r = a << b[4:0];
            4'h6: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h8: r = a >> b[4:0];
            4'h9: r = $signed(a) >>> b[4:0];
            4'hA: begin up = {32'b0, a} * {32'b0, b}; mhi = up[63:32]; mlo = up[31:0]; r = mlo; end
            4'hB: begin sp = sa * sb; mhi = sp[63:32]; mlo = sp[31:0]; r = mlo; end
            4'hC, 4'hD: begin
                if (b == 0) begin
                    mhi = a; mlo = '1; d0 = 1'b1;
                end else if (op == 4'hC) begin
                    mlo = a / b; mhi = a % b;
                end else begin
                    sq = sa / sb; sr = sa % sb; mlo = sq[31:0]; mhi = sr[31:0];
                end
                r = mlo;
            end
            4'hE: r = mhi;
            default: r = mlo;
        endcase
        return {r, (r == 0), ov, d0};
    endfunction

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_unexpected got res=%h zero=%b ovf=%b div0=%b, none expected", res, zero, ovf, div0);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({res, zero, ovf, div0} !== mon_exp)begin
                    failures++;
                    $display("FAIL scoreboard got res=%h zero=%b ovf=%b div0=%b expected res=%h zero=%b ovf=%b div0=%b",
                             res, zero, ovf, div0, mon_exp[W+2:3], mon_exp[2], mon_exp[1], mon_exp[0]);
                end
            end
            prev_pop = last_pop;
            last_pop = cyc;
        end
    end

    // Driver: present op, wait for accept, optionally measure accept-to-out_valid latency.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat);
        int n;
        int lat;
        exp_q.push_back(model_op(op, a, b));
        @(negedge clk);
        in_valid = 1'b1; A = a; B = b; AluOp = op;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL accept_timeout op=%h in_ready=%b required 1", op, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (exp_lat > 0) begin
            lat = 1;
            while (!out_valid && lat < 200) begin
                @(posedge clk);
                #1 lat++;
            end
            checks++;
            if (lat != exp_lat) begin
                failures++;
                $display("FAIL latency op=%h got %0d cycles required %0d", op, lat, exp_lat);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; AluOp = '0;
        mhi = '0; mlo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
        checks++;
        if (res !== '0) begin failures++; $display("FAIL reset_res got %h required 0", res); end
        checks++;
        if ({zero, ovf, div0} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got %b required 000", {zero, ovf, div0});
        end
        rst = 1'b0;
        send(4'hE, '0, '0, 1);
        send(4'hF, '0, '0, 1);
        drain();
    endtask

    task automatic test_add_sub();
        send(4'h2, 32'h7FFFFFFF, 32'h1, 1);
        send(4'h6, 32'h80000000, 32'h1, 1);
        send(4'h6, 32'h3, 32'h5, 1);
        send(4'h7, 32'hFFFFFFFF, 32'h1, 1);
        send(4'h4, 32'h0F0F0000, 32'h000000F0, 1);
        drain();
    endtask

    task automatic test_hold();
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(4'h6, 32'h5, 32'h5, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (!(out_valid === 1'b1 && res === '0 && zero === 1'b1 && in_ready === 1'b0)) begin
                failures++;
                $display("FAIL hold cycle %0d got out_valid=%b res=%h zero=%b in_ready=%b required 1/0/1/0",
                         i, out_valid, res, zero, in_ready);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release in_ready got %b required 1", in_ready); end
    endtask

    task automatic test_muldiv();
        send(4'hB, 32'hFFFFFFFD, 32'h7, W + 2);
        send(4'hE, '0, '0, 1);
        send(4'hF, '0, '0, 1);
        send(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, W + 2);
        send(4'hE, '0, '0, 1);
        send(4'hD, 32'hFFFFFFF9, 32'h2, W + 2);
        send(4'hE, '0, '0, 1);
        send(4'hC, 32'h9, 32'h0, 1);
        send(4'hE, '0, '0, 1);
        send(4'hD, 32'h80000000, 32'hFFFFFFFF, W + 2);
        send(4'hE, '0, '0, 1);
        send(4'hD, 32'h7, 32'hFFFFFFFE, W + 2);
        send(4'hE, '0, '0, 1);
        drain();
    endtask

    task automatic test_reset_mid();
        send(4'hA, 32'h12345678, 32'h9ABCDEF0, 0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        mhi = '0; mlo = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        send(4'hF, '0, '0, 1);
        send(4'hE, '0, '0, 1);
        drain();
    endtask

    task automatic test_back_to_back();
        send(4'h3, 32'hA5A5A5A5, 32'h0FF00FF0, 1);
        send(4'h9, 32'h80000000, 32'h4, 1);
        drain();
        checks++;
        if (last_pop - prev_pop != 1) begin
            failures++;
            $display("FAIL back_to_back spacing got %0d cycles required 1", last_pop - prev_pop);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [W-1:0] a, b;
        int lat;
        int k;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
            lat = (op == 4'hA || op == 4'hB || ((op == 4'hC || op == 4'hD) && b != 0)) ? W + 2 : 1;
            send(op, a, b, lat);
            k = $urandom_range(0, 2);
            if (k > 0) begin
                out_ready = 1'b0;
                repeat (k) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_hold();
        test_muldiv();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
